// File: rtl/pmodbtn_debounce_if.sv
// rtl/pmodbtn_debounce_if.sv - button debouncer signal bundle
// master drives raw buttons and acks; slave is the debouncer.
interface pmodbtn_debounce_if #(
  parameter int N = 4
);
  logic [N-1:0] BTN_RAW;
  logic [N-1:0] ACK;
  logic [N-1:0] BTN_STABLE;
  logic [N-1:0] BTN_PRESS;
  logic [N-1:0] BTN_RELEASE;
  logic         IRQ;

  modport master (
    output BTN_RAW,
    output ACK,
    input  BTN_STABLE,
    input  BTN_PRESS,
    input  BTN_RELEASE,
    input  IRQ
  );

  modport slave (
    input  BTN_RAW,
    input  ACK,
    output BTN_STABLE,
    output BTN_PRESS,
    output BTN_RELEASE,
    output IRQ
  );
endinterface

// File: rtl/pmodbtn_debounce.sv
// rtl/pmodbtn_debounce.sv - N-channel button debouncer with sticky press/release flags
// Define PMODBTN_IRQ_EN to build the registered IRQ; otherwise IRQ is tied low.
module pmodbtn_debounce #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                  CLK,
  input  logic                  RES,
  pmodbtn_debounce_if.slave     bus
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     s1_q, s1_d;
  logic [N-1:0]     s2_q, s2_d;
  logic [N-1:0]     stable_q, stable_d;
  logic [N-1:0]     press_q, press_d;
  logic [N-1:0]     release_q, release_d;
  logic [N-1:0]     rise, fall;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  always_comb begin
    s1_d     = bus.BTN_RAW;
    s2_d     = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      // Counter only runs while the synchronized input disagrees with the accepted level.
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_TERM) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise      = stable_d & ~stable_q;
    fall      = ~stable_d & stable_q;
    // A new event beats a same-cycle acknowledge.
    press_d   = rise | (press_q & ~bus.ACK);
    release_d = fall | (release_q & ~bus.ACK);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.BTN_STABLE  = stable_q;
  assign bus.BTN_PRESS   = press_q;
  assign bus.BTN_RELEASE = release_q;

`ifdef PMODBTN_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |(press_q | release_q);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.IRQ = irq_q;
`else
  assign bus.IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_pmodbtn_debounce.sv
// tb/tb_pmodbtn_debounce.sv - randomized and directed bench for pmodbtn_debounce
// Reference model: a level is accepted once the last D synchronized samples all oppose it.
module tb_pmodbtn_debounce;

  localparam int N = 4;
  localparam int D = 4;
  localparam int W = 3;

  logic CLK;
  logic RES;
  int   n_cmp;
  int   n_bad;

  pmodbtn_debounce_if #(.N(N)) bus ();

  pmodbtn_debounce #(
    .N(N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(W)
  ) dut (
    .CLK(CLK),
    .RES(RES),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required summary before limit");
    $fatal(1);
  end

  logic [N-1:0] m_s1, m_s2, m_stable, m_press, m_release;
  logic         m_irq;
  logic [N-1:0] hist[$];

`ifdef PMODBTN_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_stable = '0;
    m_press = '0; m_release = '0; m_irq = 1'b0;
    hist.delete();
  endtask

  // One rising edge: update the model from the inputs present at the edge.
  task automatic tick();
    logic [N-1:0] nst, rise, fall;
    bit           all_opp;
    @(posedge CLK);
    hist.push_back(m_s2);
    if (hist.size() > D) void'(hist.pop_front());
    nst = m_stable;
    if (hist.size() == D) begin
      for (int ch = 0; ch < N; ch++) begin
        all_opp = 1'b1;
        foreach (hist[k]) if (hist[k][ch] == m_stable[ch]) all_opp = 1'b0;
        if (all_opp) nst[ch] = ~m_stable[ch];
      end
    end
    rise = nst & ~m_stable;
    fall = ~nst & m_stable;
    if (IRQ_ON) m_irq = |(m_press | m_release);
    m_press   = rise | (m_press & ~bus.ACK);
    m_release = fall | (m_release & ~bus.ACK);
    m_stable  = nst;
    m_s2      = m_s1;
    m_s1      = bus.BTN_RAW;
    #1;
  endtask

  task automatic assert_reset();
    RES = 1'b1;
    model_clear();
    #2;
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #1;
    RES = 1'b0;
  endtask

  task automatic test_reset();
    bus.BTN_RAW = '0;
    bus.ACK     = '0;
    assert_reset();
    release_reset();
    n_cmp++; if (bus.BTN_STABLE !== 4'b0000) begin n_bad++; $display("FAIL reset_stable: got %b want 0000", bus.BTN_STABLE); end
    n_cmp++; if (bus.BTN_PRESS !== 4'b0000) begin n_bad++; $display("FAIL reset_press: got %b want 0000", bus.BTN_PRESS); end
    n_cmp++; if (bus.BTN_RELEASE !== 4'b0000) begin n_bad++; $display("FAIL reset_release: got %b want 0000", bus.BTN_RELEASE); end
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", bus.IRQ); end
  endtask

  task automatic test_press_latency();
    bus.BTN_RAW = 4'b0001;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 4) begin
        n_cmp++; if (bus.BTN_STABLE !== 4'b0000) begin n_bad++; $display("FAIL latency_early_e4: got %b want 0000", bus.BTN_STABLE); end
      end
      if (e == 5) begin
        n_cmp++; if (bus.BTN_STABLE !== 4'b0001) begin n_bad++; $display("FAIL latency_stable_e5: got %b want 0001", bus.BTN_STABLE); end
        n_cmp++; if (bus.BTN_PRESS !== 4'b0001) begin n_bad++; $display("FAIL latency_press_e5: got %b want 0001", bus.BTN_PRESS); end
        n_cmp++; if (bus.IRQ !== 1'b0) begin n_bad++; $display("FAIL latency_irq_e5: got %b want 0", bus.IRQ); end
      end
      if (e == 6) begin
        n_cmp++; if (bus.IRQ !== IRQ_ON) begin n_bad++; $display("FAIL latency_irq_e6: got %b want %b", bus.IRQ, IRQ_ON); end
      end
    end
  endtask

  task automatic test_ack();
    bus.ACK = 4'b0001;
    tick();
    bus.ACK = 4'b0000;
    n_cmp++; if (bus.BTN_PRESS !== 4'b0000) begin n_bad++; $display("FAIL ack_press_clear: got %b want 0000", bus.BTN_PRESS); end
    n_cmp++; if (bus.IRQ !== IRQ_ON) begin n_bad++; $display("FAIL ack_irq_lag: got %b want %b", bus.IRQ, IRQ_ON); end
    tick();
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_bad++; $display("FAIL ack_irq_drop: got %b want 0", bus.IRQ); end
  endtask

  task automatic test_glitch();
    for (int e = 0; e < 11; e++) begin
      bus.BTN_RAW = (e < 3) ? 4'b0011 : 4'b0001;
      tick();
      n_cmp++; if (bus.BTN_STABLE !== 4'b0001) begin n_bad++; $display("FAIL glitch_stable e%0d: got %b want 0001", e, bus.BTN_STABLE); end
      n_cmp++; if (bus.BTN_PRESS !== 4'b0000) begin n_bad++; $display("FAIL glitch_press e%0d: got %b want 0000", e, bus.BTN_PRESS); end
    end
  endtask

  task automatic test_ack_collision();
    bus.BTN_RAW = 4'b0000;
    assert_reset();
    release_reset();
    bus.BTN_RAW = 4'b0100;
    for (int e = 0; e <= 6; e++) begin
      bus.ACK = (e == 5) ? 4'b0100 : 4'b0000;
      tick();
      if (e == 5) begin
        n_cmp++; if (bus.BTN_STABLE !== 4'b0100) begin n_bad++; $display("FAIL collide_stable: got %b want 0100", bus.BTN_STABLE); end
        n_cmp++; if (bus.BTN_PRESS !== 4'b0100) begin n_bad++; $display("FAIL collide_press: got %b want 0100", bus.BTN_PRESS); end
      end
      if (e == 6) begin
        n_cmp++; if (bus.BTN_PRESS !== 4'b0100) begin n_bad++; $display("FAIL collide_press_hold: got %b want 0100", bus.BTN_PRESS); end
      end
    end
    bus.ACK = 4'b0000;
  endtask

  task automatic test_reset_midcount();
    bus.BTN_RAW = 4'b0000;
    assert_reset();
    release_reset();
    bus.BTN_RAW = 4'b1111;
    repeat (4) tick();
    assert_reset();
    n_cmp++; if (bus.BTN_STABLE !== 4'b0000) begin n_bad++; $display("FAIL midrst_stable: got %b want 0000", bus.BTN_STABLE); end
    n_cmp++; if (bus.BTN_PRESS !== 4'b0000) begin n_bad++; $display("FAIL midrst_press: got %b want 0000", bus.BTN_PRESS); end
    n_cmp++; if (bus.BTN_RELEASE !== 4'b0000) begin n_bad++; $display("FAIL midrst_release: got %b want 0000", bus.BTN_RELEASE); end
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_bad++; $display("FAIL midrst_irq: got %b want 0", bus.IRQ); end
    release_reset();
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (e == 4) begin
        n_cmp++; if (bus.BTN_STABLE !== 4'b0000) begin n_bad++; $display("FAIL midrst_early_e4: got %b want 0000", bus.BTN_STABLE); end
      end
      if (e == 5) begin
        n_cmp++; if (bus.BTN_STABLE !== 4'b1111) begin n_bad++; $display("FAIL midrst_stable_e5: got %b want 1111", bus.BTN_STABLE); end
        n_cmp++; if (bus.BTN_PRESS !== 4'b1111) begin n_bad++; $display("FAIL midrst_press_e5: got %b want 1111", bus.BTN_PRESS); end
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] raw;
    raw = bus.BTN_RAW;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        assert_reset();
        n_cmp++; if (bus.BTN_STABLE !== 4'b0000 || bus.BTN_PRESS !== 4'b0000 || bus.BTN_RELEASE !== 4'b0000 || bus.IRQ !== 1'b0) begin
          n_bad++; $display("FAIL rand_in_reset c%0d: got st=%b pr=%b rl=%b irq=%b want all 0", c, bus.BTN_STABLE, bus.BTN_PRESS, bus.BTN_RELEASE, bus.IRQ);
        end
        release_reset();
      end
      for (int ch = 0; ch < N; ch++) if ($urandom_range(0, 5) == 0) raw[ch] = ~raw[ch];
      bus.BTN_RAW = raw;
      for (int ch = 0; ch < N; ch++) bus.ACK[ch] = ($urandom_range(0, 7) == 0);
      tick();
      n_cmp++; if (bus.BTN_STABLE !== m_stable) begin n_bad++; $display("FAIL rand_stable c%0d: got %b want %b", c, bus.BTN_STABLE, m_stable); end
      n_cmp++; if (bus.BTN_PRESS !== m_press) begin n_bad++; $display("FAIL rand_press c%0d: got %b want %b", c, bus.BTN_PRESS, m_press); end
      n_cmp++; if (bus.BTN_RELEASE !== m_release) begin n_bad++; $display("FAIL rand_release c%0d: got %b want %b", c, bus.BTN_RELEASE, m_release); end
      n_cmp++; if (bus.IRQ !== m_irq) begin n_bad++; $display("FAIL rand_irq c%0d: got %b want %b", c, bus.IRQ, m_irq); end
    end
    bus.ACK = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RES = 1'b1;
    bus.BTN_RAW = '0;
    bus.ACK     = '0;
    model_clear();
    @(posedge CLK);
    #1;
    test_reset();
    test_press_latency();
    test_ack();
    test_glitch();
    test_ack_collision();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
